// File: rtl/wb_sdrc_traffic_gen_if.sv
// Wishbone master-side bus bundle for the SDRAM traffic generator.
interface wb_sdrc_traffic_gen_if #(
  parameter int AW = 26,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic [2:0]      cti;
  logic            ack;
  logic [DW-1:0]   dat_r;

  modport master (
    output cyc, stb, we, addr, dat_w, sel, cti,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, addr, dat_w, sel, cti,
    output ack, dat_r
  );
endinterface

// File: rtl/wb_sdrc_traffic_gen.sv
// Self-checking Wishbone master: writes LFSR bursts, reads them back, counts mismatches.
// WB_TRAFFIC_BURST_EN selects incrementing bursts (cti 010/111) instead of classic single cycles.
module wb_sdrc_traffic_gen #(
  parameter int          AW   = 26,
  parameter int          DW   = 32,
  parameter int          BLEN = 8,
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic [AW-1:0]         base_addr_i,
  input  logic [15:0]           num_bursts_i,
  input  logic                  sdr_init_done_i,
  wb_sdrc_traffic_gen_if.master wb,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [15:0]           err_cnt_o,
  output logic [AW-1:0]         first_err_addr_o
);
  localparam int          STEP = DW / 8;
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_INIT, S_WR, S_RD, S_DONE} state_t;

  state_t        r_state;
  logic [31:0]   r_lfsr;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_base;
  logic [15:0]   r_num;
  logic [15:0]   r_burst;
  logic [3:0]    r_beat;
  logic          r_stb;
  logic          r_we;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [15:0]   r_err;
  logic [AW-1:0] r_ferr;

  logic          w_ack;
  logic          w_last_beat;
  logic          w_last_burst;
  logic          w_mis;
  logic [31:0]   w_lfsr_nxt;
  logic [15:0]   w_err_nxt;

  assign w_ack        = r_stb & wb.ack;
  assign w_last_beat  = (r_beat == 4'(BLEN - 1));
  assign w_last_burst = (r_burst == (r_num - 16'd1));
  assign w_mis        = (wb.dat_r != r_lfsr[DW-1:0]);
  // Galois form, shifting right; POLY holds the x^32, x^22, x^2, x^1 feedback taps.
  assign w_lfsr_nxt   = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? POLY : 32'h0);
  assign w_err_nxt    = (r_state == S_RD && w_ack && w_mis && r_err != 16'hFFFF)
                        ? r_err + 16'd1 : r_err;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_addr  <= '0;
      r_base  <= '0;
      r_num   <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ferr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_base  <= base_addr_i;
            r_addr  <= base_addr_i;
            r_num   <= num_bursts_i;
            r_lfsr  <= SEED;
            r_beat  <= '0;
            r_burst <= '0;
            r_err   <= '0;
            r_ferr  <= '0;
            if (num_bursts_i == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_WAIT_INIT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
        S_WAIT_INIT: begin
          if (sdr_init_done_i) begin
            r_state <= S_WR;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
          end
        end
        S_WR, S_RD: begin
          if (w_ack) begin
            r_addr <= r_addr + AW'(STEP);
            r_lfsr <= w_lfsr_nxt;
            r_err  <= w_err_nxt;
            if (r_state == S_RD && w_mis && r_err == 16'd0)
              r_ferr <= r_addr;
            if (w_last_beat) begin
              r_beat <= '0;
              r_stb  <= 1'b0;
              if (w_last_burst) begin
                r_burst <= '0;
                r_we    <= 1'b0;
                if (r_state == S_WR) begin
                  // Read-back replays the same sequence from the same start point.
                  r_state <= S_RD;
                  r_addr  <= r_base;
                  r_lfsr  <= SEED;
                end else begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_nxt == 16'd0);
                end
              end else begin
                r_burst <= r_burst + 16'd1;
              end
            end else begin
              r_beat <= r_beat + 4'd1;
`ifndef WB_TRAFFIC_BURST_EN
              r_stb  <= 1'b0;
`endif
            end
          end else if (!r_stb) begin
            r_stb <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb.cyc  = r_stb;
  assign wb.stb  = r_stb;
  assign wb.we   = r_we;
  assign wb.addr = r_addr;
  assign wb.dat_w = (r_stb && r_we) ? r_lfsr[DW-1:0] : '0;
  assign wb.sel  = {STEP{r_stb}};
`ifdef WB_TRAFFIC_BURST_EN
  assign wb.cti  = r_stb ? (w_last_beat ? 3'b111 : 3'b010) : 3'b000;
`else
  assign wb.cti  = 3'b000;
`endif

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign err_cnt_o        = r_err;
  assign first_err_addr_o = r_ferr;
endmodule

// File: tb/tb_wb_sdrc_traffic_gen.sv
// Scoreboard bench for wb_sdrc_traffic_gen: memory slave model, per-beat checks, end-of-run result checks.
module tb_wb_sdrc_traffic_gen;
  localparam int          AW   = 26;
  localparam int          DW   = 32;
  localparam int          BLEN = 8;
  localparam logic [31:0] SEED = 32'hACE1_2345;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic [2:0]    cti;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [15:0]   num;
  logic          init_done;
  logic          busy, done, pass;
  logic [15:0]   err;
  logic [AW-1:0] ferr;

  always #5 clk = ~clk;

  wb_sdrc_traffic_gen_if #(.AW(AW), .DW(DW)) wb ();

  wb_sdrc_traffic_gen #(.AW(AW), .DW(DW), .BLEN(BLEN), .SEED(SEED)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .start_i         (start),
    .base_addr_i     (base),
    .num_bursts_i    (num),
    .sdr_init_done_i (init_done),
    .wb              (wb.master),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_cnt_o       (err),
    .first_err_addr_o(ferr)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  beat_t         exp_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            run_id       = 0;
  int            hold_after   = -1;
  int            ack_cnt      = 0;
  logic          stall_en     = 1'b0;
  logic          corrupt_en   = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [2:0] exp_cti(input int beat);
`ifdef WB_TRAFFIC_BURST_EN
    return (beat == BLEN - 1) ? 3'b111 : 3'b010;
`else
    return (beat >= 0) ? 3'b000 : 3'b000;
`endif
  endfunction

  // Wishbone slave + monitor: acks, returns memory data, pops and compares every acked beat.
  initial begin
    int    my_run = -1;
    int    beats = 0;
    int    low = 0;
    logic  a;
    logic  prev_ack = 1'b0;
    logic  exp_stb_after = 1'b0;
    beat_t act, e;
    wb.ack   = 1'b0;
    wb.dat_r = '0;
    forever begin
      @(negedge clk);
      if (run_id != my_run) begin
        my_run = run_id; beats = 0; low = 0; prev_ack = 1'b0;
      end
      if (prev_ack && !rst) check("stb_after_ack", wb.stb, exp_stb_after);
      if (wb.stb === 1'b1 && low > 0) begin
        if (beats > 0) check("inter_cycle_gap", low, 1);
        low = 0;
      end else if (wb.stb !== 1'b1) begin
        low++;
      end
      a = (wb.cyc === 1'b1) && (wb.stb === 1'b1) && !rst
          && !(hold_after >= 0 && beats >= hold_after)
          && !(stall_en && $urandom_range(0, 2) == 0);
      wb.ack = a;
      if (wb.stb === 1'b1 && wb.we === 1'b0)
        wb.dat_r = (mem.exists(wb.addr) ? mem[wb.addr] : '0)
                   ^ ((corrupt_en && wb.addr == corrupt_addr) ? 32'h1 : 32'h0);
      if (a) begin
        act = {wb.we, wb.addr, (wb.we ? wb.dat_w : {DW{1'b0}}), wb.cti};
        if (exp_q.size() == 0) begin
          check("unexpected_beat", act, 64'h0);
          exp_stb_after = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("beat", act, e);
          exp_stb_after = (e.cti == 3'b010);
        end
        if (wb.we) mem[wb.addr] = wb.dat_w;
        beats++;
        ack_cnt++;
      end
      prev_ack = a;
    end
  end

  task automatic push_run(input logic [AW-1:0] b, input int n);
    logic [31:0]   l;
    logic [AW-1:0] ad;
    beat_t         e;
    for (int ph = 0; ph < 2; ph++) begin
      l  = SEED;
      ad = b;
      for (int i = 0; i < n * BLEN; i++) begin
        e.we   = (ph == 0);
        e.addr = ad;
        e.dat  = (ph == 0) ? l[DW-1:0] : '0;
        e.cti  = exp_cti(i % BLEN);
        exp_q.push_back(e);
        ad = ad + AW'(DW / 8);
        l  = lfsr_next(l);
      end
    end
  endtask

  task automatic start_run(input logic [AW-1:0] b, input int n, input bit chk_lat);
    run_id++;
    push_run(b, n);
    @(negedge clk);
    base = b; num = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (chk_lat) begin
      check("latency_cycle1_stb", wb.stb, 0);
      @(negedge clk);
      check("latency_cycle2_stb", wb.stb, 1);
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 5000 && done !== 1'b1; k++) @(negedge clk);
    check({name, "_done"}, done, 1);
  endtask

  task automatic check_result(input string name, input logic p, input logic [15:0] ec,
                              input logic [AW-1:0] fa);
    check({name, "_pass"}, pass, p);
    check({name, "_err_cnt"}, err, ec);
    check({name, "_first_err"}, ferr, fa);
    check({name, "_busy"}, busy, 0);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int            cnt;
    int            c0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_dat;

    rst = 1'b1; start = 1'b0; base = '0; num = '0; init_done = 1'b1;
    repeat (5) @(negedge clk);
    // T1: reset state, then idle with no start
    check("rst_cyc_stb_we", {wb.cyc, wb.stb, wb.we}, 0);
    check("rst_addr", wb.addr, 0);
    check("rst_dat_sel_cti", {wb.dat_w, wb.sel, wb.cti}, 0);
    check("rst_status", {busy, done, pass}, 0);
    check("rst_err_ferr", {err, ferr}, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (100) begin @(negedge clk); if (wb.stb !== 1'b0) cnt++; end
    check("idle_no_stb", cnt, 0);

    start_run('0, 0, 0);
    wait_done("zero_bursts");
    check_result("zero_bursts", 1'b1, 16'd0, '0);

    // T2: one burst at 0x100
    start_run(AW'('h100), 1, 1);
    wait_done("t2");
    check_result("t2", 1'b1, 16'd0, '0);
    check("t2_mem_first", mem[AW'('h100)], 32'hACE1_2345);
    check("t2_mem_second", mem[AW'('h104)], 32'hD650_91A1);

    // T3: corrupt read beat 3 of the second burst
    stall_en = 1'b1; corrupt_en = 1'b1; corrupt_addr = AW'('h2C);
    start_run('0, 2, 0);
    wait_done("t3");
    check_result("t3", 1'b0, 16'd1, AW'('h2C));
    corrupt_en = 1'b0;

    // T4: address wrap at the top of the space
    start_run(AW'((1 << AW) - 8), 1, 0);
    wait_done("t4");
    check_result("t4", 1'b1, 16'd0, '0);
    check("t4_mem_wrapped", mem[AW'(0)], 32'hEB08_48D3);
    stall_en = 1'b0;

    // T5: controller not ready for 500 cycles; starts while busy are ignored
    init_done = 1'b0;
    start_run(AW'('h200), 1, 0);
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wb.stb !== 1'b0) cnt++;
      if (i == 250) begin base = AW'('h3000); num = 16'd4; start = 1'b1; end
      if (i == 251) start = 1'b0;
    end
    check("t5_no_stb_before_init", cnt, 0);
    check("t5_busy_waiting", busy, 1);
    init_done = 1'b1;
    repeat (4) @(negedge clk);
    base = AW'('h3000); num = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5");
    check_result("t5", 1'b1, 16'd0, '0);
    repeat (3) @(negedge clk);
    check("t5_done_sticky", {done, pass}, 2'b11);

    // T6: reset while beat 4 of a write is pending
    hold_after = 3;
    c0 = ack_cnt;
    start_run(AW'('h40), 2, 0);
    for (int k = 0; k < 200 && (ack_cnt - c0) < 3; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t6_beat4_pending", {wb.stb, wb.we}, 2'b11);
    hold_addr = wb.addr;
    hold_dat  = wb.dat_w;
    check("t6_beat4_addr", hold_addr, AW'('h4C));
    repeat (3) @(negedge clk);
    check("t6_hold_stable", {wb.addr, wb.dat_w}, {hold_addr, hold_dat});
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_cyc_stb", {wb.cyc, wb.stb}, 0);
    check("t6_rst_status", {busy, done, err}, 0);
    rst = 1'b0;
    hold_after = -1;
    exp_q.delete();
    start_run(AW'('h40), 2, 1);
    wait_done("t6");
    check_result("t6", 1'b1, 16'd0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
